// File: rtl/alu_ser_pkg.sv
// Shared types and helpers for the ALU result serializer.
package alu_ser_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Circular result buffer; full/empty derived from the registered count.
module alu_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and sends each as an async serial frame:
// start, 8 data bits LSB-first, optional even parity, stop.
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  output logic       res_ready,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] frame_cnt
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ser_state_e           state;
  logic [BW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_cnt;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 bit_end;

  assign push      = ena && res_valid && !fifo_full;
  assign drop      = ena && res_valid && fifo_full;
  assign pop       = ena && (state == IDLE) && !fifo_empty;
  assign bit_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign res_ready = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_cnt != '0);

  alu_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (res_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      tx        <= 1'b1;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else if (ena) begin
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      if (state == IDLE) begin
        baud_cnt <= '0;
        if (!fifo_empty) begin
          shift   <= fifo_rdata;
          par     <= even_parity(fifo_rdata);
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            tx    <= shift[0];
            state <= DATA;
          end
          DATA: begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              if (PARITY_EN) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
          PARITY: begin
            tx    <= 1'b1;
            state <= STOP;
          end
          default: begin
            tx        <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer (CLKS_PER_BIT=4, FIFO_DEPTH=4, parity on).
module tb_alu_result_serializer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic       ovf_clr;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap;
  logic [63:0] expv;
  logic [10:0] fbits;
  logic [7:0]  rx_d;
  logic        bad;

  alu_result_serializer #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .PARITY_EN    (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .ovf_clr   (ovf_clr),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ena       = 1'b1;
    res_valid = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Receive one frame, sampling each bit in the middle of its 4 cycles.
  task automatic rx_frame(output logic [7:0] d);
    int n;
    n = 0;
    d = '0;
    while (tx !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      check("rx_timeout", 64'(tx), 64'(0));
    end else begin
      repeat (2) tick();
      check("rx_start", 64'(tx), 64'(0));
      for (int b = 0; b < 8; b++) begin
        repeat (4) tick();
        d[b] = tx;
      end
      repeat (4) tick();
      check("rx_parity", 64'(tx), 64'(^d));
      repeat (4) tick();
      check("rx_stop", 64'(tx), 64'(1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    res_valid = 1'b1;
    res_data  = 8'h55;
    ovf_clr   = 1'b0;

    // Reset held with res_valid asserted
    repeat (3) tick();
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_ready", 64'(res_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_fcnt", 64'(frame_cnt), 64'(0));
    res_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (2) tick();
    check("rst_nopush_busy", 64'(busy), 64'(0));
    check("rst_nopush_tx", 64'(tx), 64'(1));

    // Single frame 0xA5: start, 10100101 LSB-first, parity 0, stop
    res_data  = 8'hA5;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("a5_latency_pre", 64'(tx), 64'(1));
    tick();
    fbits = 11'b10101001010;
    cap   = '0;
    expv  = '0;
    for (int i = 0; i < 44; i++) begin
      expv[i] = fbits[i/4];
      cap[i]  = tx;
      if (i == 43) check("a5_fcnt_before_end", 64'(frame_cnt), 64'(0));
      tick();
    end
    check("a5_waveform", cap, expv);
    check("a5_fcnt", 64'(frame_cnt), 64'(1));
    check("a5_busy", 64'(busy), 64'(0));
    check("a5_tx_idle", 64'(tx), 64'(1));

    // Burst 0x01..0x06; 0x06 dropped while full
    do_reset();
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          res_data  = 8'(k);
          res_valid = 1'b1;
          if (k == 6) check("burst_ready_full", 64'(res_ready), 64'(0));
          tick();
          if (k == 2) check("burst_first_start", 64'(tx), 64'(0));
        end
        res_valid = 1'b0;
        check("burst_ovf", 64'(overflow), 64'(1));
      end
      begin
        for (int f = 0; f < 5; f++) begin
          rx_frame(rx_d);
          check("burst_data", 64'(rx_d), 64'(f + 1));
        end
      end
    join
    wait_idle();
    check("burst_fcnt", 64'(frame_cnt), 64'(5));

    // Overflow clear alone, then clear colliding with a drop
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clear", 64'(overflow), 64'(0));
    for (int k = 0; k < 6; k++) begin
      res_data  = 8'h11 + 8'(k);
      res_valid = 1'b1;
      ovf_clr   = (k == 5);
      if (k == 5) check("ovf_full_ready", 64'(res_ready), 64'(0));
      tick();
    end
    res_valid = 1'b0;
    ovf_clr   = 1'b0;
    check("ovf_set_wins", 64'(overflow), 64'(1));
    wait_idle();
    check("ovf_fcnt", 64'(frame_cnt), 64'(10));

    // ena low for 10 cycles mid-DATA of 0x3C
    do_reset();
    res_data  = 8'h3C;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    fbits = 11'b10001111000;
    cap   = '0;
    expv  = '0;
    for (int i = 0; i < 54; i++) begin
      if (i <= 13)      expv[i] = fbits[i/4];
      else if (i <= 23) expv[i] = fbits[13/4];
      else              expv[i] = fbits[(i-10)/4];
      cap[i] = tx;
      if (i == 53) check("ena_fcnt_before_end", 64'(frame_cnt), 64'(0));
      ena = !(i >= 13 && i <= 22);
      tick();
    end
    ena = 1'b1;
    check("ena_waveform", cap, expv);
    check("ena_fcnt", 64'(frame_cnt), 64'(1));

    // Reset mid-DATA with two entries queued
    do_reset();
    for (int k = 0; k < 3; k++) begin
      res_data  = 8'h81 >> k;
      res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    repeat (10) tick();
    check("midrst_busy_pre", 64'(busy), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_tx", 64'(tx), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ready", 64'(res_ready), 64'(1));
    check("midrst_fcnt", 64'(frame_cnt), 64'(0));
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("midrst_quiet", 64'(bad), 64'(0));
    check("midrst_fcnt_after", 64'(frame_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
